// File: rtl/multi_sequencer.sv
// Step sequencer and run-control block for the multicycle MIPS core.
// Owns the per-instruction step counter, inserts memory wait-states,
// provides free-run / single-step control and stops on halt or faults.
// `advance` gates every architectural write enable in the datapath.
module multi_sequencer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             step_req,
    input  logic             clear,
    input  logic             next_ins,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_op,
    output logic [2:0]       state,
    output logic             advance,
    output logic             running,
    output logic             halted,
    output logic [1:0]       fault,
    output logic             step_ack,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_RUN    = 2'd1,
        MODE_HALTED = 2'd2,
        MODE_FAULT  = 2'd3
    } mode_t;

    localparam logic [1:0]       FAULT_NONE    = 2'd0;
    localparam logic [1:0]       FAULT_TIMEOUT = 2'd1;
    localparam logic [1:0]       FAULT_OVERFLOW = 2'd2;
    // Wait-counter value seen on the WAIT_MAX-th consecutive wait cycle.
    localparam logic [7:0]       WAIT_LAST     = 8'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    mode_t            mode_reg, mode_next;
    logic [2:0]       state_reg, state_next;
    logic             single_reg, single_next;
    logic [7:0]       wcnt_reg, wcnt_next;
    logic [1:0]       fault_reg, fault_next;
    logic             step_ack_reg, step_ack_next;
    logic [CNT_W-1:0] instr_count_reg, instr_count_next;
    logic [CNT_W-1:0] cycle_count_reg, cycle_count_next;

    logic mem_wait;

    assign mem_wait = mem_req & ~mem_ready;

    // Commit strobe: only in RUN and only when memory is not stalling the step.
    assign advance     = (mode_reg == MODE_RUN) && !mem_wait;
    assign running     = (mode_reg == MODE_RUN);
    assign halted      = (mode_reg == MODE_HALTED);
    assign state       = state_reg;
    assign fault       = fault_reg;
    assign step_ack    = step_ack_reg;
    assign instr_count = instr_count_reg;
    assign cycle_count = cycle_count_reg;

    // State register with asynchronous reset; reset aborts any in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg        <= MODE_IDLE;
            state_reg       <= 3'd0;
            single_reg      <= 1'b0;
            wcnt_reg        <= 8'd0;
            fault_reg       <= FAULT_NONE;
            step_ack_reg    <= 1'b0;
            instr_count_reg <= '0;
            cycle_count_reg <= '0;
        end else begin
            mode_reg        <= mode_next;
            state_reg       <= state_next;
            single_reg      <= single_next;
            wcnt_reg        <= wcnt_next;
            fault_reg       <= fault_next;
            step_ack_reg    <= step_ack_next;
            instr_count_reg <= instr_count_next;
            cycle_count_reg <= cycle_count_next;
        end
    end

    // Next-state logic: mode transitions, step sequencing, wait/timeout and counters.
    always_comb begin
        mode_next        = mode_reg;
        state_next       = state_reg;
        single_next      = single_reg;
        wcnt_next        = wcnt_reg;
        fault_next       = fault_reg;
        step_ack_next    = 1'b0;
        instr_count_next = instr_count_reg;
        cycle_count_next = cycle_count_reg;

        case (mode_reg)
            MODE_IDLE: begin
                // run_en wins over step_req.
                if (run_en) begin
                    mode_next   = MODE_RUN;
                    single_next = 1'b0;
                end else if (step_req) begin
                    mode_next   = MODE_RUN;
                    single_next = 1'b1;
                end
            end

            MODE_RUN: begin
                cycle_count_next = cycle_count_reg + CNT_ONE;
                if (mem_wait) begin
                    wcnt_next = wcnt_reg + 8'd1;
                    if (wcnt_reg == WAIT_LAST) begin
                        mode_next  = MODE_FAULT;
                        fault_next = FAULT_TIMEOUT;
                    end
                end else begin
                    wcnt_next = 8'd0;
                    if (next_ins) begin
                        state_next       = 3'd0;
                        instr_count_next = instr_count_reg + CNT_ONE;
                        if (halt_op) begin
                            mode_next = MODE_HALTED;
                        end else if (single_reg) begin
                            mode_next     = MODE_IDLE;
                            step_ack_next = 1'b1;
                            single_next   = 1'b0;
                        end else if (!run_en) begin
                            // run_en is only honoured at an instruction boundary.
                            mode_next = MODE_IDLE;
                        end
                    end else if (state_reg == 3'd7) begin
                        // No room for another step: controller lost track of the boundary.
                        mode_next  = MODE_FAULT;
                        fault_next = FAULT_OVERFLOW;
                    end else begin
                        state_next = state_reg + 3'd1;
                    end
                end
            end

            MODE_HALTED, MODE_FAULT: begin
                // Counters are preserved across clear so software can inspect them.
                if (clear) begin
                    mode_next  = MODE_IDLE;
                    state_next = 3'd0;
                    fault_next = FAULT_NONE;
                    wcnt_next  = 8'd0;
                end
            end

            default: begin
                mode_next = MODE_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_sequencer.sv
// Directed testbench for multi_sequencer: free run, single step, wait states,
// boundary stop, timeout, step overflow and asynchronous reset.
module tb_multi_sequencer;

    logic        clk;
    logic        rst;
    logic        run_en;
    logic        step_req;
    logic        clear;
    logic        next_ins;
    logic        mem_req;
    logic        mem_ready;
    logic        halt_op;
    logic [2:0]  state;
    logic        advance;
    logic        running;
    logic        halted;
    logic [1:0]  fault;
    logic        step_ack;
    logic [31:0] instr_count;
    logic [31:0] cycle_count;

    int checks_total  = 0;
    int checks_passed = 0;

    multi_sequencer #(
        .WAIT_MAX(15),
        .CNT_W   (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_en     (run_en),
        .step_req   (step_req),
        .clear      (clear),
        .next_ins   (next_ins),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .halt_op    (halt_op),
        .state      (state),
        .advance    (advance),
        .running    (running),
        .halted     (halted),
        .fault      (fault),
        .step_ack   (step_ack),
        .instr_count(instr_count),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_state"},   32'(state), 0);
        check_val({tag, "_advance"}, 32'(advance), 0);
        check_val({tag, "_running"}, 32'(running), 0);
        check_val({tag, "_halted"},  32'(halted), 0);
        check_val({tag, "_fault"},   32'(fault), 0);
        check_val({tag, "_ack"},     32'(step_ack), 0);
        check_val({tag, "_icnt"},    instr_count, 0);
        check_val({tag, "_ccnt"},    cycle_count, 0);
    endtask

    initial begin
        rst       = 1'b1;
        run_en    = 1'b0;
        step_req  = 1'b0;
        clear     = 1'b0;
        next_ins  = 1'b0;
        mem_req   = 1'b0;
        mem_ready = 1'b1;
        halt_op   = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check_val("idle_state", 32'(state), 0);

        // ---- Free run: 4-step instructions, HALT on the 5th ----
        run_en = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            next_ins = (i % 4 == 3);
            halt_op  = (i == 19);
            #1;
            check_val($sformatf("run_state%0d", i), 32'(state), 32'(i % 4));
            check_val($sformatf("run_adv%0d", i), 32'(advance), 1);
            $display("free run cycle %0d: state=%0d advance=%0d", i, state, advance);
            tick();
        end
        next_ins = 1'b0;
        halt_op  = 1'b0;
        #1;
        check_val("run_halted", 32'(halted), 1);
        check_val("run_icnt",   instr_count, 5);
        check_val("run_ccnt",   cycle_count, 20);
        check_val("run_adv_after", 32'(advance), 0);
        check_val("run_state_after", 32'(state), 0);
        tick();
        check_val("halt_hold", 32'(halted), 1);
        run_en = 1'b0;
        clear  = 1'b1;
        tick();
        clear = 1'b0;
        check_val("clr_halted", 32'(halted), 0);
        check_val("clr_running", 32'(running), 0);
        check_val("clr_icnt", instr_count, 5);
        check_val("clr_ccnt", cycle_count, 20);

        // ---- Single step: 3-step instruction, extra step_req mid-instruction ----
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_ins = (i == 2);
            step_req = (i == 1);
            #1;
            check_val($sformatf("ss_adv%0d", i), 32'(advance), 1);
            check_val($sformatf("ss_state%0d", i), 32'(state), 32'(i));
            $display("single step cycle %0d: state=%0d advance=%0d", i, state, advance);
            tick();
        end
        next_ins = 1'b0;
        step_req = 1'b0;
        check_val("ss_ack", 32'(step_ack), 1);
        check_val("ss_running", 32'(running), 0);
        check_val("ss_state", 32'(state), 0);
        check_val("ss_icnt", instr_count, 6);
        tick();
        check_val("ss_ack_low", 32'(step_ack), 0);
        check_val("ss_still_idle", 32'(running), 0);
        check_val("ss_ccnt", cycle_count, 23);

        // ---- Wait states at step 0, then run_en dropped at step 1 ----
        run_en = 1'b1;
        tick();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val($sformatf("ws_adv%0d", i), 32'(advance), 0);
            check_val($sformatf("ws_state%0d", i), 32'(state), 0);
            $display("wait cycle %0d: state=%0d advance=%0d", i, state, advance);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check_val("ws_release_adv", 32'(advance), 1);
        tick();
        mem_req = 1'b0;
        check_val("ws_state1", 32'(state), 1);
        run_en = 1'b0;
        tick();
        check_val("bs_state2", 32'(state), 2);
        check_val("bs_running", 32'(running), 1);
        tick();
        next_ins = 1'b1;
        check_val("bs_state3", 32'(state), 3);
        tick();
        next_ins = 1'b0;
        check_val("bs_idle", 32'(running), 0);
        check_val("bs_state", 32'(state), 0);
        check_val("bs_icnt", instr_count, 7);
        check_val("ws_ccnt", cycle_count, 31);

        // ---- Memory timeout after 15 wait cycles ----
        run_en = 1'b1;
        tick();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check_val($sformatf("to_nofault%0d", i), 32'(fault), 0);
            tick();
        end
        check_val("to_fault", 32'(fault), 1);
        check_val("to_running", 32'(running), 0);
        check_val("to_ccnt", cycle_count, 46);
        $display("timeout: fault=%0d cycle_count=%0d", fault, cycle_count);
        mem_req = 1'b0;
        run_en  = 1'b0;
        tick();
        check_val("to_fault_hold", 32'(fault), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("to_clr_fault", 32'(fault), 0);
        check_val("to_clr_icnt", instr_count, 7);
        check_val("to_clr_ccnt", cycle_count, 46);
        mem_ready = 1'b1;

        // ---- Step overflow: next_ins never asserted ----
        run_en = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("ov_state%0d", i), 32'(state), 32'(i));
            tick();
        end
        check_val("ov_fault", 32'(fault), 2);
        check_val("ov_state", 32'(state), 7);
        check_val("ov_adv", 32'(advance), 0);
        check_val("ov_ccnt", cycle_count, 54);
        $display("overflow: fault=%0d state=%0d", fault, state);
        run_en = 1'b0;
        clear  = 1'b1;
        tick();
        clear = 1'b0;
        check_val("ov_clr_state", 32'(state), 0);

        // ---- Asynchronous reset mid-wait ----
        run_en = 1'b1;
        tick();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("areset");
        $display("async reset: state=%0d running=%0d icnt=%0d", state, running, instr_count);
        run_en  = 1'b0;
        mem_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_val("post_reset_running", 32'(running), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/multi_sequencer.md
# multi_sequencer

Step sequencer and run-control block for the multicycle MIPS core. It owns the 3-bit per-instruction step counter `state` consumed by the multicycle controller, and returns it to 0 when the controller raises `next_ins`. It inserts memory wait-states, provides free-run and single-step debug control, and stops on halt or sequencing faults. Its `advance` output gates every architectural write enable in the datapath: PC, IR, register file and memory write.

## Interface
Parameters:
- `WAIT_MAX`, 15: maximum consecutive memory wait cycles before a fault; range 1..255.
- `CNT_W`, 32: width of the retired-instruction and cycle counters.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `run_en` in 1: level; free-run request.
- `step_req` in 1: pulse; execute exactly one instruction. Sampled only in IDLE.
- `clear` in 1: pulse; leave HALTED or FAULT and return to IDLE.
- `next_ins` in 1: from the controller; the current step is the last step of the instruction.
- `mem_req` in 1: from the controller; the current step accesses memory.
- `mem_ready` in 1: memory completes the access this cycle.
- `halt_op` in 1: the decoded instruction is HALT. Valid whenever `next_ins`=1.
- `state` out 3: step index to the controller.
- `advance` out 1: combinational; the current step commits this cycle.
- `running` out 1: mode is RUN.
- `halted` out 1: mode is HALTED.
- `fault` out 2: 0 = none, 1 = memory timeout, 2 = step overflow.
- `step_ack` out 1: one-cycle pulse after a single-stepped instruction retires.
- `instr_count` out CNT_W: retired-instruction count.
- `cycle_count` out CNT_W: count of RUN-mode cycles.

## Operation
- Modes are IDLE, RUN, HALTED and FAULT. There is also an internal `single` flag and a wait counter `wcnt` (8 bit).
- On reset: mode=IDLE, `state`=0, `single`=0, `wcnt`=0, `fault`=0, `step_ack`=0, both counters 0. `advance`, `running` and `halted` read 0.
- IDLE:
  - `advance`=0.
  - If `run_en`=1, go to RUN with `single`=0. `run_en` takes priority over `step_req`.
  - Otherwise, if `step_req`=1, go to RUN with `single`=1.
- RUN is evaluated every cycle as follows.
  - Wait case: `mem_req`=1 and `mem_ready`=0.
    - `advance`=0 and `wcnt` increments.
    - If `wcnt`=WAIT_MAX-1 at that edge, go to FAULT with `fault`=1.
  - Otherwise `advance`=1, `wcnt` is cleared to 0, and exactly one of the following applies.
  - Retire case: `next_ins`=1.
    - `state`←0 and `instr_count`++.
    - Then the first matching rule applies, in this priority order:
      - `halt_op`=1 → HALTED.
      - `single`=1 → IDLE, `step_ack` pulses, `single` cleared.
      - `run_en`=0 → IDLE.
      - Otherwise stay in RUN.
  - Overflow case: `next_ins`=0 and `state`=7. Go to FAULT with `fault`=2; `state` is held at 7.
  - Normal case: `state`++.
- `cycle_count` increments on every cycle spent in RUN, including wait cycles.
- Deasserting `run_en` mid-instruction does not stop the block early; it stops only at the next instruction boundary.
- `step_req` is ignored outside IDLE.
- HALTED and FAULT:
  - `advance`=0.
  - `state`, the counters and `fault` are held.
  - `clear`=1 → IDLE, with `state`=0, `fault`=0 and `wcnt`=0. Both counters are preserved.
- Both counters wrap modulo 2^CNT_W with no saturation.
- Asserting `rst` mid-instruction aborts the instruction immediately. Because `advance` drops to 0, no partial write commits after reset.

## Timing
- `state`, the mode, `step_ack` and the counters are registered. `advance` is a combinational function of the mode, `mem_req` and `mem_ready`.
- Exit from IDLE takes one cycle: the first cycle with `advance`=1 is the cycle after `run_en` or `step_req` is sampled.
- An instruction of N steps with no waits takes N cycles in RUN. Each wait cycle adds exactly one cycle.
- `step_ack` is high for exactly the one cycle after the retiring edge.
- `halted` asserts in the cycle after the HALT instruction's retiring edge.
- A timeout is reached after exactly WAIT_MAX consecutive wait cycles. On the following cycle `fault`=1.

## Test plan
- Free run:
  - Stimulus: reset, `run_en`=1, controller raises `next_ins` at step 3 (4-step instructions), no waits, `halt_op` on the 5th instruction.
  - Required: `state` sequence 0,1,2,3 repeating; `instr_count`=5; `cycle_count`=20; `halted`=1; `advance`=0 afterwards.
- Single step:
  - Stimulus: one `step_req` pulse in IDLE, 3-step instruction.
  - Required: `advance` high for 3 cycles; `step_ack` one pulse; back in IDLE with `state`=0 and `instr_count`=1. A second `step_req` issued mid-instruction is ignored.
- Wait states:
  - Stimulus: `mem_req`=1 at step 0 with `mem_ready` low for 4 cycles.
  - Required: `state` holds 0 and `advance`=0 for 4 cycles, then the instruction proceeds; `cycle_count` includes the 4 wait cycles.
- Timeout:
  - Stimulus: `WAIT_MAX`=15, `mem_ready` held low.
  - Required: `fault`=1 after 15 wait cycles; `clear` returns the block to IDLE with `fault`=0 and counters unchanged.
- Overflow and boundary stop:
  - Stimulus A: `next_ins` never asserted. Required: `fault`=2 with `state`=7.
  - Stimulus B: drop `run_en` at step 1. Required: the instruction completes and the block enters IDLE at the boundary.
- Async reset:
  - Stimulus: assert `rst` mid-wait, between clock edges.
  - Required: all outputs take their reset values immediately.
